imm_encoder: RTL

- Inverse of the decode-stage immediate extraction. Accepts instruction fields plus a full 32-bit immediate, packs them into a 32-bit RV32I instruction word and checks that the immediate is representable in the chosen format.
- Output is registered behind a valid/ready handshake, with a word-address counter for streaming into instruction memory.
- Used by the program loader and by verification benches to generate instruction streams.

---
 rtl/imm_encoder_if.sv | 36 +++
 rtl/imm_encoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: bundles the input fields, the valid/ready handshakes and the
// registered outputs of imm_encoder.
//   master : the producer of fields and consumer of words (loader / bench)
//   slave  : the encoder itself
// Fields in : in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready
// Fields out: in_ready, out_valid, instr, imm_err, out_addr, err_count
interface imm_encoder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            fmt;
  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [31:0]           imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           instr;
  logic                  imm_err;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [7:0]            err_count;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, imm_err, out_addr, err_count
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr, imm_err, out_addr, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs RV32I instruction fields and a full 32-bit immediate into
// an instruction word, flagging immediates the chosen format cannot represent.
// One-deep registered output stage with valid/ready, a word-address counter
// and a saturating count of errored words.
// Ports:
//   CLK    : clock, rising edge
//   RESET  : asynchronous active-low reset
//   clear  : synchronous clear of out_addr (to BASE_ADDR) and err_count
//   bus    : imm_encoder_if.slave (fields in, encoded word out)
module imm_encoder #(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          clear,
  imm_encoder_if.slave  bus
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Returns {imm_err, instr}. Out-of-range immediates still encode the
  // truncated bits so the word is inspectable; reserved formats give zero.
  function automatic logic [32:0] encode(
    input logic [2:0]  fmt,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic        err;
    w   = 32'h0000_0000;
    err = 1'b0;
    case (fmt)
      FMT_R: begin
        w   = {funct7, rs2, rs1, funct3, rd, opcode};
        err = 1'b0;
      end
      FMT_I: begin
        w   = {imm[11:0], rs1, funct3, rd, opcode};
        err = ~((&imm[31:11]) | ~(|imm[31:11]));
      end
      FMT_S: begin
        w   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err = ~((&imm[31:11]) | ~(|imm[31:11]));
      end
      FMT_B: begin
        w   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err = ~((&imm[31:12]) | ~(|imm[31:12])) | imm[0];
      end
      FMT_U: begin
        w   = {imm[31:12], rd, opcode};
        err = |imm[11:0];
      end
      FMT_J: begin
        w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err = ~((&imm[31:20]) | ~(|imm[31:20])) | imm[0];
      end
      default: begin
        w   = 32'h0000_0000;
        err = 1'b1;
      end
    endcase
    return {err, w};
  endfunction

  logic                  out_valid_q, out_valid_d;
  logic [31:0]           instr_q, instr_d;
  logic                  imm_err_q, imm_err_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [7:0]            err_count_q, err_count_d;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  emit_s;
  logic [32:0]           enc_s;

  // Handshake decode and combinational encode of the presented fields.
  always_comb begin
    in_ready_s = ~out_valid_q | bus.out_ready;
    accept_s   = bus.in_valid & in_ready_s;
    emit_s     = out_valid_q & bus.out_ready;
    enc_s      = encode(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                        bus.funct3, bus.funct7, bus.imm);
  end

  // Next-state for the output stage and counters; clear overrides the
  // address increment of a simultaneous emit.
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    imm_err_d   = imm_err_q;
    out_addr_d  = out_addr_q;
    err_count_d = err_count_q;

    if (accept_s) begin
      out_valid_d = 1'b1;
      instr_d     = enc_s[31:0];
      imm_err_d   = enc_s[32];
    end else if (emit_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (clear) begin
      out_addr_d  = BASE_ADDR;
      err_count_d = 8'h00;
    end else if (emit_s) begin
      out_addr_d = out_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (imm_err_q && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'h01;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      out_addr_d  = out_addr_q;
      err_count_d = err_count_q;
    end
  end

  // Output stage and counter registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'h0000_0000;
      imm_err_q   <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      err_count_q <= 8'h00;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      imm_err_q   <= imm_err_d;
      out_addr_q  <= out_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign bus.imm_err   = imm_err_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.err_count = err_count_q;

endmodule
